// File: rtl/cdc_handshake_rx.sv
// Destination-domain half of a 4-phase req/ack crossing.
// It synchronizes req, captures the word the source is holding, offers that
// word on a valid/ready port, and then returns ack to the source.
//
// state | meaning
// IDLE  | waiting for synchronized req; no word held
// HOLD  | word captured and offered on m_valid/m_data; ack withheld
// ACK   | word consumed; ack high until synchronized req falls
module cdc_handshake_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  async_req,
  input  logic [DATA_WIDTH-1:0] async_data,
  output logic                  async_ack,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_WIDTH-1:0]   sync_q, sync_d;
  logic                    ack_q, ack_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic                    req_s;

  // async_req is only ever sampled by the first flop of this chain.
  assign req_s = sync_q[SYNC_WIDTH-1];

  // Next-state and output decisions for the handshake FSM.
  always_comb begin
    sync_d  = {sync_q[SYNC_WIDTH-2:0], async_req};
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          data_d  = async_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // An early req drop is flagged, but the held word is still delivered
        // so that the consumer never loses data it was already offered.
        if (!req_s) begin
          err_d = 1'b1;
        end
        if (valid_q && m_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    // busy is registered from the next state, so it tracks state_q exactly.
    busy_d = (state_d != IDLE);
  end

  // All state and outputs are registered, so ack to the source is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign async_ack = ack_q;
  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign busy      = busy_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Testbench for cdc_handshake_rx. Every word the source offers is queued, and
// a monitor pops that queue on each accepted word at the consumer port.
module tb_cdc_handshake_rx;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          async_req = 1'b0;
  logic [DW-1:0] async_data = '0;
  logic          m_ready = 1'b0;

  logic          async_ack, m_valid, busy, proto_err;
  logic [DW-1:0] m_data;
  logic          a4_ack, v4_valid, b4_busy, e4_err;
  logic [DW-1:0] d4_data;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  logic [DW-1:0] exp_q[$];
  logic src_done;

  always #5 clk = ~clk;

  cdc_handshake_rx #(.DATA_WIDTH(DW), .SYNC_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .async_req(async_req), .async_data(async_data),
    .async_ack(async_ack), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .proto_err(proto_err)
  );

  cdc_handshake_rx #(.DATA_WIDTH(DW), .SYNC_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .async_req(async_req), .async_data(async_data),
    .async_ack(a4_ack), .m_valid(v4_valid), .m_data(d4_data),
    .m_ready(m_ready), .busy(b4_busy), .proto_err(e4_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one accepted word per cycle where valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_word: got %0h expected none", m_data);
      end else begin
        check("m_data_order", 64'(m_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    async_req = 1'b0;
    m_ready = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input logic val, input string name);
    int k;
    k = 0;
    while (async_ack !== val && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(async_ack), 64'(val));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ack"},   64'(async_ack), 64'd0);
    check({name, "_valid"}, 64'(m_valid),   64'd0);
    check({name, "_data"},  64'(m_data),    64'd0);
    check({name, "_busy"},  64'(busy),      64'd0);
    check({name, "_err"},   64'(proto_err), 64'd0);
  endtask

  // Behavioural source: runs on its own random period, unrelated to clk.
  task automatic source_run(input int nwords, input int p);
    int k;
    logic [DW-1:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = $urandom;
      async_data = w;
      exp_q.push_back(w);
      #(p);
      async_req = 1'b1;
      k = 0;
      while (async_ack !== 1'b1 && k < 5000) begin #(p); k++; end
      if (async_ack !== 1'b1) begin
        check("stream_ack_rise_timeout", 64'(async_ack), 64'd1);
        break;
      end
      #(p * $urandom_range(0, 3));
      async_req = 1'b0;
      k = 0;
      while (async_ack !== 1'b0 && k < 5000) begin #(p); k++; end
      if (async_ack !== 1'b0) begin
        check("stream_ack_fall_timeout", 64'(async_ack), 64'd0);
        break;
      end
      #(p);
    end
    src_done = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int p;
    logic [DW-1:0] w;

    // Reset state.
    rst_n = 1'b0;
    #3;
    check_all_zero("reset");
    do_reset();
    check_all_zero("post_reset");

    // Basic transfer with SYNC_WIDTH=2.
    async_data = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    m_ready = 1'b1;
    async_req = 1'b1;
    tick(); check("basic_valid_e0", 64'(m_valid), 64'd0);
    tick(); check("basic_valid_e1", 64'(m_valid), 64'd0);
    tick(); check("basic_valid_e2", 64'(m_valid), 64'd1);
    check("basic_data_e2", 64'(m_data), 64'hDEADBEEF);
    check("basic_busy_e2", 64'(busy), 64'd1);
    check("basic_ack_e2", 64'(async_ack), 64'd0);
    tick(); check("basic_ack_e3", 64'(async_ack), 64'd1);
    check("basic_valid_e3", 64'(m_valid), 64'd0);
    async_req = 1'b0;
    tick(); check("basic_ack_drop1", 64'(async_ack), 64'd1);
    tick(); check("basic_ack_drop2", 64'(async_ack), 64'd1);
    tick(); check("basic_ack_drop3", 64'(async_ack), 64'd0);
    check("basic_busy_end", 64'(busy), 64'd0);
    check("basic_data_held", 64'(m_data), 64'hDEADBEEF);
    m_ready = 1'b0;

    // Back-pressure: the word and ack must not move while m_ready=0.
    w = $urandom;
    async_data = w;
    exp_q.push_back(w);
    async_req = 1'b1;
    repeat (3) tick();
    check("bp_valid_rise", 64'(m_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid_stable", 64'(m_valid), 64'd1);
      check("bp_data_stable", 64'(m_data), 64'(w));
      check("bp_ack_low", 64'(async_ack), 64'd0);
    end
    acc0 = n_acc;
    m_ready = 1'b1;
    tick();
    check("bp_ack_rise", 64'(async_ack), 64'd1);
    check("bp_valid_fall", 64'(m_valid), 64'd0);
    repeat (2) tick();
    check("bp_one_accept", 64'(n_acc - acc0), 64'd1);
    async_req = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    m_ready = 1'b0;
    tick();

    // Streaming from a source with a random period.
    do_reset();
    p = $urandom_range(3, 37);
    src_done = 1'b0;
    acc0 = n_acc;
    fork
      source_run(100, p);
      begin
        while (!src_done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b0;
    repeat (6) tick();
    check("stream_count", 64'(n_acc - acc0), 64'd100);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);
    check("stream_no_err", 64'(proto_err), 64'd0);

    // Protocol violation: req drops while the word is still held.
    do_reset();
    w = $urandom;
    async_data = w;
    exp_q.push_back(w);
    async_req = 1'b1;
    repeat (3) tick();
    check("viol_valid", 64'(m_valid), 64'd1);
    tick();
    async_req = 1'b0;
    repeat (4) tick();
    check("viol_err_set", 64'(proto_err), 64'd1);
    check("viol_still_valid", 64'(m_valid), 64'd1);
    check("viol_ack_low", 64'(async_ack), 64'd0);
    m_ready = 1'b1;
    tick();
    check("viol_ack_rise", 64'(async_ack), 64'd1);
    check("viol_valid_fall", 64'(m_valid), 64'd0);
    tick();
    check("viol_ack_fall", 64'(async_ack), 64'd0);
    check("viol_idle", 64'(busy), 64'd0);
    repeat (5) tick();
    check("viol_err_sticky", 64'(proto_err), 64'd1);
    check("viol_queue_empty", 64'(exp_q.size()), 64'd0);
    m_ready = 1'b0;

    // Reset while in HOLD: the captured word is dropped.
    do_reset();
    async_data = $urandom;
    async_req = 1'b1;
    repeat (4) tick();
    check("rsthold_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_in_hold");
    async_req = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rsthold_idle", 64'(busy), 64'd0);
    check("rsthold_novalid", 64'(m_valid), 64'd0);

    // Reset while in ACK.
    w = $urandom;
    async_data = w;
    exp_q.push_back(w);
    m_ready = 1'b1;
    async_req = 1'b1;
    wait_ack(1'b1, "rstack_ack_rise");
    check("rstack_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_in_ack");
    async_req = 1'b0;
    m_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("rstack_idle", 64'(busy), 64'd0);
    check("rstack_ack_low", 64'(async_ack), 64'd0);

    // SYNC_WIDTH=4 instance: same sequence, four-edge capture latency.
    do_reset();
    w = 32'hDEADBEEF;
    async_data = w;
    exp_q.push_back(w);
    m_ready = 1'b1;
    async_req = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("sw4_valid_early", 64'(v4_valid), 64'd0);
    end
    tick();
    check("sw4_valid_e4", 64'(v4_valid), 64'd1);
    check("sw4_data_e4", 64'(d4_data), 64'hDEADBEEF);
    tick();
    check("sw4_ack_e5", 64'(a4_ack), 64'd1);
    async_req = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("sw4_ack_hold", 64'(a4_ack), 64'd1);
    end
    tick();
    check("sw4_ack_fall", 64'(a4_ack), 64'd0);
    check("sw4_idle", 64'(b4_busy), 64'd0);
    check("sw4_no_err", 64'(e4_err), 64'd0);
    m_ready = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
